// File: rtl/note_sequencer.sv
// Record/playback sequencer for note vectors: records OR-accumulated notes per beat,
// plays them back once or in a loop, tracks recorded length and sticky overflow.
module note_sequencer #(
    parameter int NOTE_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  period,
    input  logic [NOTE_W-1:0] note_in,
    output logic [NOTE_W-1:0] note_out,
    output logic              beat,
    output logic              busy,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] address,
    output logic [ADDR_W:0]   length,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RECORD = 2'b01,
        S_PLAY   = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    per_q, per_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                ovf_q, ovf_d;
    logic                loop_q, loop_d;
    logic [NOTE_W-1:0]   acc_q, acc_d;
    logic [NOTE_W-1:0]   note_q, note_d;

    logic [NOTE_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [NOTE_W-1:0]   mem_wdata;

    logic                busy_c;
    logic                beat_c;
    logic [CNT_W-1:0]    per_sel;
    logic [ADDR_W-1:0]   addr_inc;
    logic [ADDR_W:0]     next_len;

    assign busy_c   = (state_q != S_IDLE);
    assign beat_c   = busy_c && (cnt_q == '0);
    assign per_sel  = (period == '0) ? CNT_W'(1) : period;
    assign addr_inc = addr_q + ADDR_W'(1);
    assign next_len = (ADDR_W+1)'(addr_q) + (ADDR_W+1)'(1);

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        loop_d    = loop_q;
        acc_d     = acc_q;
        note_d    = note_q;
        mem_we    = 1'b0;
        mem_wdata = acc_q | note_in;

        // stop outranks the beat event, so a stop on a beat cycle writes nothing
        if (stop && busy_c) begin
            state_d = S_IDLE;
            addr_d  = '0;
            note_d  = '0;
        end else begin
            case (state_q)
                S_RECORD: begin
                    if (beat_c) begin
                        cnt_d  = per_q - CNT_W'(1);
                        mem_we = 1'b1;
                        note_d = mem_wdata;
                        acc_d  = '0;
                        len_d  = next_len;
                        if (addr_q == ADDR_W'(DEPTH - 1)) begin
                            ovf_d   = 1'b1;
                            state_d = S_IDLE;
                            addr_d  = '0;
                        end else begin
                            addr_d = addr_inc;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        acc_d = mem_wdata;
                    end
                end
                S_PLAY: begin
                    note_d = mem_q[addr_q];
                    if (beat_c) begin
                        cnt_d = per_q - CNT_W'(1);
                        if (next_len < len_q) begin
                            addr_d = addr_inc;
                        end else if (loop_q) begin
                            addr_d = '0;
                        end else begin
                            state_d = S_IDLE;
                            addr_d  = '0;
                            note_d  = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    note_d = '0;
                    if (start && !stop) begin
                        case (mode)
                            2'b01: begin
                                state_d = S_RECORD;
                                addr_d  = '0;
                                acc_d   = '0;
                                ovf_d   = 1'b0;
                                len_d   = '0;
                                per_d   = per_sel;
                                cnt_d   = per_sel - CNT_W'(1);
                            end
                            2'b00, 2'b10: begin
                                if (len_q != '0) begin
                                    state_d = S_PLAY;
                                    addr_d  = '0;
                                    loop_d  = mode[1];
                                    note_d  = mem_q[0];
                                    per_d   = per_sel;
                                    cnt_d   = per_sel - CNT_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            per_q   <= CNT_W'(1);
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            loop_q  <= 1'b0;
            acc_q   <= '0;
            note_q  <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            loop_q  <= loop_d;
            acc_q   <= acc_d;
            note_q  <= note_d;
        end
    end

    // Memory has no reset; reset only blocks a write that would land in the same cycle
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[addr_q] <= mem_wdata;
        end
    end

    assign note_out = note_q;
    assign beat     = beat_c;
    assign busy     = busy_c;
    assign state    = state_q;
    assign address  = addr_q;
    assign length   = len_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer (DEPTH=4): directed scenarios then random
// stimulus, every cycle compared against a rule-level reference model.
module tb_note_sequencer;

    localparam int NOTE_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset, start, stop;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  period;
    logic [NOTE_W-1:0] note_in;
    logic [NOTE_W-1:0] note_out;
    logic              beat, busy, overflow;
    logic [1:0]        state;
    logic [ADDR_W-1:0] address;
    logic [ADDR_W:0]   length;

    int n_vec = 0;
    int n_err = 0;

    note_sequencer #(
        .NOTE_W(NOTE_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .period  (period),
        .note_in (note_in),
        .note_out(note_out),
        .beat    (beat),
        .busy    (busy),
        .state   (state),
        .address (address),
        .length  (length),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 record, 2 play
    int          m_state = 0;
    int          m_per = 1, m_cnt = 0, m_addr = 0, m_len = 0;
    bit          m_ovf = 0, m_loop = 0;
    logic [31:0] m_acc = '0, m_note = '0;
    logic [31:0] m_mem [DEPTH];

    task automatic model_step();
        bit          bt;
        logic [31:0] v;
        int          p;
        if (reset) begin
            m_state = 0; m_cnt = 0; m_addr = 0; m_len = 0;
            m_ovf = 0; m_acc = '0; m_note = '0;
            return;
        end
        bt = (m_state != 0) && (m_cnt == 0);
        p  = (period == 0) ? 1 : int'(period);
        if (stop && m_state != 0) begin
            m_state = 0; m_addr = 0; m_note = '0;
        end else if (m_state == 1) begin
            m_cnt = bt ? m_per - 1 : m_cnt - 1;
            if (bt) begin
                v = m_acc | note_in;
                m_mem[m_addr] = v;
                m_note = v;
                m_acc = '0;
                m_len = m_addr + 1;
                if (m_addr == DEPTH - 1) begin
                    m_ovf = 1; m_state = 0; m_addr = 0;
                end else begin
                    m_addr++;
                end
            end else begin
                m_acc = m_acc | note_in;
            end
        end else if (m_state == 2) begin
            v = m_mem[m_addr];
            m_cnt = bt ? m_per - 1 : m_cnt - 1;
            if (bt) begin
                if (m_addr + 1 < m_len) m_addr++;
                else if (m_loop) m_addr = 0;
                else begin m_state = 0; m_addr = 0; v = '0; end
            end
            m_note = v;
        end else begin
            m_note = '0;
            if (start && !stop) begin
                if (mode == 2'b01) begin
                    m_state = 1; m_addr = 0; m_acc = '0; m_ovf = 0; m_len = 0;
                    m_per = p; m_cnt = p - 1;
                end else if (mode != 2'b11 && m_len != 0) begin
                    m_state = 2; m_addr = 0; m_loop = (mode == 2'b10);
                    m_note = m_mem[0];
                    m_per = p; m_cnt = p - 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("state",    64'(state),    64'(m_state));
        chk("busy",     64'(busy),     64'(m_state != 0));
        chk("beat",     64'(beat),     64'((m_state != 0) && (m_cnt == 0)));
        chk("note_out", 64'(note_out), 64'(m_note));
        chk("address",  64'(address),  64'(m_addr));
        chk("length",   64'(length),   64'(m_len));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic go(input logic [1:0] md, input int per);
        mode = md; period = CNT_W'(per); start = 1'b1;
        tick();
    endtask

    task automatic rec_slots(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        go(2'b01, 2);
        note_in = a; tick(); tick();
        note_in = b; tick(); tick();
        note_in = c; tick(); tick();
        note_in = '0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
        period = '0; note_in = '0;
        tick();
        reset = 1'b1;
        tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_note",  64'(note_out), 64'd0);

        // Sticky capture within a beat: 0x1 then 0x40 merges into 0x41
        note_in = 32'h5;
        go(2'b01, 3);
        note_in = 32'h1; tick(); tick();
        note_in = 32'h40; tick();
        chk("rec_mem0",  64'(note_out), 64'h41);
        chk("rec_len1",  64'(length), 64'd1);
        for (int i = 0; i < 9; i++) begin
            note_in = $urandom; tick();
        end
        chk("ovf_flag",  64'(overflow), 64'd1);
        chk("ovf_len",   64'(length), 64'd4);
        chk("ovf_state", 64'(state), 64'd0);

        // Record 1,2,4 then stop mid-beat
        rec_slots(32'h1, 32'h2, 32'h4);
        note_in = 32'h80; tick();
        stop = 1'b1; tick();
        chk("stop_len", 64'(length), 64'd3);

        go(2'b00, 2);
        chk("play_first", 64'(note_out), 64'h1);
        mode = 2'b10;
        for (int i = 0; i < 7; i++) tick();
        chk("once_end_state", 64'(state), 64'd0);
        chk("once_end_note",  64'(note_out), 64'd0);

        go(2'b10, 2);
        for (int i = 0; i < 9; i++) tick();
        stop = 1'b1; tick();
        chk("loop_stop_state", 64'(state), 64'd0);
        chk("loop_stop_busy",  64'(busy), 64'd0);
        chk("loop_stop_note",  64'(note_out), 64'd0);

        // Start and stop together in IDLE
        start = 1'b1; stop = 1'b1; mode = 2'b00; tick();
        chk("start_stop_idle", 64'(state), 64'd0);

        // period 0: a beat every cycle, start in RECORD ignored, stop on beat wins
        go(2'b01, 0);
        note_in = $urandom; tick();
        start = 1'b1; mode = 2'b00; note_in = $urandom; tick();
        stop = 1'b1; note_in = $urandom; tick();
        chk("p0_len",   64'(length), 64'd2);
        chk("p0_state", 64'(state), 64'd0);

        reset = 1'b1; tick();
        go(2'b00, 1);
        chk("empty_play_state", 64'(state), 64'd0);
        chk("empty_play_busy",  64'(busy), 64'd0);

        rec_slots(32'h10, 32'h20, 32'h30);
        go(2'b10, 1);
        tick(); tick();
        reset = 1'b1; tick();
        chk("rst_play_state", 64'(state), 64'd0);
        chk("rst_play_len",   64'(length), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(7) == 0);
            stop    = ($urandom_range(40) == 0);
            reset   = ($urandom_range(600) == 0);
            mode    = 2'($urandom_range(3));
            period  = CNT_W'($urandom_range(3));
            note_in = ($urandom_range(3) == 0) ? (32'h1 << $urandom_range(31)) : '0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Parametrised record/playback sequencer for guitar note vectors. It generalises the fixed 64x32 recorder into a block with configurable note width, memory depth and beat period. It adds a loop-play mode, recorded-length tracking, overflow detection and a clean stop. It sits between the string/fret note encoder, which drives note_in, and the audio/hex display path, which consumes note_out.

Parameters:
NOTE_W, 32, width of one note vector (one bit per string/fret position)
DEPTH, 64, number of note slots in internal memory (power of two, >=2)
ADDR_W, 6, address width, equal to log2(DEPTH)
CNT_W, 27, width of beat period counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins the operation selected by mode (IDLE only)
stop  input  1  one-cycle pulse; aborts RECORD/PLAY and returns to IDLE
mode  input  2  00 play once, 01 record, 10 loop play, 11 reserved (start ignored)
period  input  CNT_W  beat length in clk cycles, sampled on accepted start; 0 treated as 1
note_in  input  NOTE_W  live note vector from encoder
note_out  output  NOTE_W  registered playback/monitor note
beat  output  1  one-cycle pulse at each beat boundary in RECORD/PLAY
busy  output  1  high in RECORD or PLAY
state  output  2  00 IDLE, 01 RECORD, 10 PLAY
address  output  ADDR_W  current slot index
length  output  ADDR_W+1  number of valid recorded slots (0..DEPTH)
overflow  output  1  sticky; set when a recording fills all DEPTH slots

Behaviour:
- Reset: state=IDLE, note_out=0, beat=0, busy=0, address=0, length=0, overflow=0, accumulator=0, counter=0. Memory contents are not cleared and are don't-care after reset.
- Priority each cycle: reset > stop > beat event > start.
- Beat timer: on accepted start, per_q<=max(period,1) and counter<=per_q-1. In RECORD/PLAY the counter decrements each cycle. When counter==0: beat=1 for that cycle and counter reloads per_q-1. First beat therefore occurs per_q cycles after the start cycle. per_q=1 gives a beat every cycle.
- IDLE: start with mode=01 -> RECORD, address<=0, accumulator<=0, overflow<=0, length<=0.
- IDLE: start with mode=00/10 -> PLAY, address<=0. If length==0, stay IDLE instead.
- IDLE: start with mode=11 is ignored. note_out<=0 while IDLE.
- RECORD: every non-beat cycle, accumulator<=accumulator|note_in (sticky capture of anything played within the beat).
- RECORD: on a beat cycle, mem[address]<=accumulator|note_in, note_out<=the same value (monitor), accumulator<=0, length<=address+1.
- RECORD: if address==DEPTH-1 at that beat -> overflow<=1, state<=IDLE, address<=0. Otherwise address<=address+1.
- RECORD: stop -> IDLE. The partial beat is discarded and length keeps its last written value.
- PLAY: note_out<=mem[address] every cycle (registered, 1-cycle read latency), so mem[0] appears the cycle after start.
- PLAY: on a beat cycle, if address+1<length then address<=address+1.
- PLAY: else in play-once -> IDLE, address<=0, note_out<=0. Else in loop -> address<=0 and playback continues until stop.
- PLAY: mode changes during PLAY are ignored; the mode is latched at start.
- start while busy is ignored. start and stop in the same IDLE cycle -> stays IDLE.
- Reset mid-operation returns to IDLE at the next clk edge. length/overflow are cleared and the memory is untouched.
- address wraps only through the explicit rules above and never runs past DEPTH-1.

Test Plan:
- DEPTH=4, period=3, mode=01, note_in=0x1 for 2 cycles then 0x40 until the 1st beat -> mem[0]=0x41. The beat pulses at cycles 3, 6, 9. length increments 1, 2, 3.
- Record with DEPTH=4, period=2, no stop -> after the 4th beat overflow=1, state=IDLE, length=4, address=0.
- Record 3 slots {0x1, 0x2, 0x4}, then mode=00, period=2 -> note_out=0x1 from the cycle after start, then 0x2, then 0x4. After the 3rd beat state=IDLE and note_out=0.
- Same data, mode=10 -> note_out sequence 1, 2, 4, 1, 2, 4, ... Stop pulse mid-sequence -> next cycle state=IDLE, note_out=0, busy=0.
- period=0, record -> beat every cycle, one slot per cycle. start pulsed during RECORD has no effect. A stop arriving on a beat cycle wins and no write occurs.
- After a reset, issue mode=00 start -> it is rejected because length=0: state stays IDLE and busy=0. A reset asserted mid-PLAY -> all outputs at reset values on the next cycle.
